fetch_sequencer: RTL and testbench

Sequences the program counter and instruction fetch for the CPU datapath. Owns the architectural fetch PC, which resets to 32'h0000_3000. Issues word requests to instruction memory over a req/ack handshake and hands each fetched instruction to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and discards any fetch made on the wrong path.

---
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues instruction-memory word requests
// over a req/ack handshake and hands fetched words to decode over valid/ready.
// Redirects from execute discard any fetch made on the wrong path.
// Optional build macro FETCH_EXC_EN adds exception entry/return (exc_req,
// eret, epc) with priority exc_req > eret > redir_valid.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef FETCH_EXC_EN
    ,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic [31:0] pc
`ifdef FETCH_EXC_EN
    ,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // request outstanding on the correct path
        HOLD  = 2'd1,  // instruction presented to decode, no request
        DROP  = 2'd2   // request outstanding on a wrong path, data discarded
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
`ifdef FETCH_EXC_EN
    logic [31:0] r_epc;
`endif

    logic        w_take;
    logic [31:0] w_target;

    // Select the redirect source and force the target word-aligned.
    always_comb begin
        w_take   = redir_valid;
        w_target = redir_target & 32'hFFFF_FFFC;
`ifdef FETCH_EXC_EN
        if (exc_req) begin
            w_take   = 1'b1;
            w_target = EXC_VEC & 32'hFFFF_FFFC;
        end else if (eret) begin
            w_take   = 1'b1;
            w_target = r_epc & 32'hFFFF_FFFC;
        end
`endif
    end

    // Fetch FSM with all outputs registered. r_req resets low so no request
    // is visible while rst is high; the first clock after release raises it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
            r_inst    <= 32'h0;
            r_inst_pc <= 32'h0;
`ifdef FETCH_EXC_EN
            r_epc     <= 32'h0;
`endif
        end else begin
`ifdef FETCH_EXC_EN
            // Save the PC of the instruction being pre-empted.
            if (exc_req)
                r_epc <= (r_state == HOLD) ? r_inst_pc : r_pc;
`endif
            case (r_state)
                FETCH: begin
                    if (!r_req) begin
                        // First cycle out of reset: start the request,
                        // redirecting it first if asked.
                        r_req <= 1'b1;
                        if (w_take) begin
                            r_pc   <= w_target;
                            r_addr <= w_target;
                        end
                    end else if (w_take) begin
                        r_pc <= w_target;
                        if (imem_ack)
                            r_addr <= w_target;  // old data dropped, reissue
                        else
                            r_state <= DROP;     // must wait out old request
                    end else if (imem_ack) begin
                        r_inst    <= imem_rdata;
                        r_inst_pc <= r_addr;
                        r_pc      <= r_pc + 32'd4;
                        r_valid   <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    // A redirect beats inst_ready: the held word is discarded.
                    if (w_take) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end else if (inst_ready) begin
                        r_valid <= 1'b0;
                        r_addr  <= r_pc;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                DROP: begin
                    if (w_take)
                        r_pc <= w_target;
                    if (imem_ack) begin
                        r_addr  <= w_take ? w_target : r_pc;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = r_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc         = r_pc;
`ifdef FETCH_EXC_EN
    assign epc        = r_epc;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios pinned with literal values,
// then randomized traffic compared every cycle against a transaction-level
// model (outstanding request + wrong-path flag + pending instruction).
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] pc;
`ifdef FETCH_EXC_EN
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] m_epc;
`endif

    fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .pc           (pc)
`ifdef FETCH_EXC_EN
        ,
        .exc_req      (exc_req),
        .eret         (eret),
        .epc          (epc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: architectural pc, the outstanding request (if any) and
    // whether it is on a wrong path, and the instruction held for decode.
    logic [31:0] m_pc, m_addr, m_inst, m_inst_pc;
    bit          m_req, m_wrong, m_valid;
    int          mw;  // remaining wait cycles of the memory model

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h3000; m_addr = 32'h3000; m_inst = 0; m_inst_pc = 0;
        m_req = 0; m_wrong = 0; m_valid = 0; mw = 0;
`ifdef FETCH_EXC_EN
        m_epc = 0;
`endif
    endtask

    task automatic check_model();
        chk("imem_req",   {31'b0, imem_req},   {31'b0, m_req});
        chk("imem_addr",  imem_addr,           m_addr);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        chk("inst",       inst,                m_inst);
        chk("inst_pc",    inst_pc,             m_inst_pc);
        chk("pc",         pc,                  m_pc);
`ifdef FETCH_EXC_EN
        chk("epc",        epc,                 m_epc);
`endif
    endtask

    // Advance the model by one clock using the inputs just driven.
    task automatic model_step();
        bit          take;
        logic [31:0] t;
        take = redir_valid;
        t    = redir_target & ~32'h3;
`ifdef FETCH_EXC_EN
        if (exc_req)   begin take = 1; t = 32'h4180; end
        else if (eret) begin take = 1; t = m_epc;    end
        if (exc_req) m_epc = m_valid ? m_inst_pc : m_pc;
`endif
        if (!m_req && !m_valid) begin
            m_req = 1;
            if (take) begin m_pc = t; m_addr = t; end
        end else if (m_valid) begin
            if (take) begin
                m_valid = 0; m_pc = t; m_req = 1; m_addr = t;
            end else if (inst_ready) begin
                m_valid = 0; m_req = 1; m_addr = m_pc;
            end
        end else begin
            if (take) m_pc = t;
            if (imem_ack) begin
                if (m_wrong || take) begin
                    m_wrong = 0; m_addr = m_pc;
                end else begin
                    m_inst = imem_rdata; m_inst_pc = m_addr;
                    m_pc = m_pc + 32'd4; m_req = 0; m_valid = 1;
                end
            end else if (take) begin
                m_wrong = 1;
            end
        end
    endtask

    // Called at a falling edge: compare, drive the next inputs, step the
    // model, then wait for the next falling edge.
    task automatic cyc(input bit a, input bit rv, input logic [31:0] tgt, input bit rdy);
        check_model();
        imem_ack     = a;
        redir_valid  = rv;
        redir_target = tgt;
        inst_ready   = rdy;
        imem_rdata   = memword(m_addr);
        model_step();
        @(negedge clk);
`ifdef FETCH_EXC_EN
        exc_req = 0;
        eret    = 0;
`endif
    endtask

    task automatic reset_lits(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req},   32'h0);
        chk({tag, "_addr"},  imem_addr,           32'h3000);
        chk({tag, "_pc"},    pc,                  32'h3000);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_inst"},  inst,                32'h0);
        chk({tag, "_ipc"},   inst_pc,             32'h0);
`ifdef FETCH_EXC_EN
        chk({tag, "_epc"},   epc,                 32'h0);
`endif
    endtask

    task automatic rand_cycles(input int n);
        bit          a, rv, rdy;
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            if (m_req) begin
                if (mw == 0) begin a = 1; mw = $urandom_range(0, 3); end
                else begin a = 0; mw--; end
            end else begin
                a = ($urandom % 8) == 0;  // spurious ack, must be ignored
            end
            rv  = ($urandom % 6) == 0;
            tgt = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            rdy = ($urandom % 3) != 0;
`ifdef FETCH_EXC_EN
            exc_req = ($urandom % 25) == 0;
            eret    = ($urandom % 25) == 0;
`endif
            cyc(a, rv, tgt, rdy);
        end
    endtask

    initial begin
        rst = 1; imem_ack = 0; imem_rdata = 0; inst_ready = 0;
        redir_valid = 0; redir_target = 0;
`ifdef FETCH_EXC_EN
        exc_req = 0; eret = 0;
`endif
        model_reset();
        @(negedge clk); @(negedge clk);
        reset_lits("rst");
        rst = 0;

        // Zero-wait memory, ready high: one instruction every two cycles.
        cyc(0, 0, 0, 1);
        chk("wake_req", {31'b0, imem_req}, 32'h1);
        chk("wake_addr", imem_addr, 32'h3000);
        cyc(1, 0, 0, 1);
        chk("zw_valid0", {31'b0, inst_valid}, 32'h1);
        chk("zw_ipc0", inst_pc, 32'h3000);
        chk("zw_pc0", pc, 32'h3004);
        cyc(1, 0, 0, 1);
        chk("zw_addr1", imem_addr, 32'h3004);
        chk("zw_valid_gap", {31'b0, inst_valid}, 32'h0);
        cyc(1, 0, 0, 1);
        chk("zw_ipc1", inst_pc, 32'h3004);
        chk("zw_inst1", inst, memword(32'h3004));
        cyc(1, 0, 0, 1);
        chk("zw_addr2", imem_addr, 32'h3008);
        cyc(1, 0, 0, 1);
        chk("zw_ipc2", inst_pc, 32'h3008);
        cyc(1, 0, 0, 1);
        chk("zw_addr3", imem_addr, 32'h300C);

        // Ack delayed three cycles: request stable throughout.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            chk("dly_req", {31'b0, imem_req}, 32'h1);
            chk("dly_addr", imem_addr, 32'h300C);
            chk("dly_valid", {31'b0, inst_valid}, 32'h0);
        end
        cyc(1, 0, 0, 0);
        chk("dly_valid_after_ack", {31'b0, inst_valid}, 32'h1);
        chk("dly_ipc", inst_pc, 32'h300C);

        // Stall in HOLD, then redirect to an unaligned target.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0);
            chk("hold_ipc", inst_pc, 32'h300C);
            chk("hold_req", {31'b0, imem_req}, 32'h0);
        end
        cyc(0, 1, 32'h3103, 1);
        chk("hredir_valid", {31'b0, inst_valid}, 32'h0);
        chk("hredir_addr", imem_addr, 32'h3100);

        // Redirect before ack: DROP holds the old address.
        cyc(0, 1, 32'h3200, 0);
        chk("drop_addr", imem_addr, 32'h3100);
        chk("drop_pc", pc, 32'h3200);
        cyc(0, 0, 0, 0);
        chk("drop_addr2", imem_addr, 32'h3100);
        cyc(1, 0, 0, 0);
        chk("drop_discard", {31'b0, inst_valid}, 32'h0);
        chk("drop_newaddr", imem_addr, 32'h3200);
        cyc(1, 0, 0, 0);
        chk("drop_ipc", inst_pc, 32'h3200);

        // Redirect with simultaneous ack to the top word, then wrap.
        cyc(0, 0, 0, 1);
        cyc(1, 1, 32'hFFFF_FFFE, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_novalid", {31'b0, inst_valid}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'h0);

`ifdef FETCH_EXC_EN
        cyc(0, 1, 32'h3010, 1);
        cyc(1, 0, 0, 0);
        chk("exc_pre_ipc", inst_pc, 32'h3010);
        exc_req = 1;
        cyc(0, 0, 0, 0);
        chk("exc_epc", epc, 32'h3010);
        chk("exc_addr", imem_addr, 32'h4180);
        cyc(1, 0, 0, 0);
        eret = 1;
        cyc(0, 0, 0, 0);
        chk("eret_addr", imem_addr, 32'h3010);
        cyc(1, 0, 0, 0);
        exc_req = 1;
        cyc(0, 1, 32'h5000, 0);
        chk("exc_prio_addr", imem_addr, 32'h4180);
`endif

        rand_cycles(3000);

        // Asynchronous reset with a request outstanding.
        for (int i = 0; i < 6 && !(m_req && !m_valid); i++) cyc(0, 0, 0, 1);
        #2 rst = 1;
        #1 reset_lits("async_rst");
        imem_ack = 0; redir_valid = 0; inst_ready = 0;
        @(negedge clk);
        reset_lits("rst_hold");
        rst = 0;
        model_reset();
        rand_cycles(300);
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
